// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised RX_IN, per-frame latched Prescale/parity config, one-cycle result pulses.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote over samples at P/2-1, P/2, P/2+1 instead of a single P/2 sample.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, rx_s_q;
  logic [5:0]            p_q, p_d;
  logic [5:0]            edge_q, edge_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  pen_q, pen_d, ptyp_q, ptyp_d;
  logic                  par_bad_q, par_bad_d;
  logic                  stop_ok_q, stop_ok_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;

  logic [5:0] p_sel, half;
  logic       at_dec, bit_last, bit_val;

  assign p_sel    = (Prescale == 6'd16 || Prescale == 6'd32) ? Prescale : 6'd8;
  assign half     = p_q >> 1;
  assign at_dec   = (edge_q == half + 6'd1);
  assign bit_last = (edge_q == p_q - 6'd1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      rx_s_q  <= sync1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s0_q, s1_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      if (edge_q == half - 6'd1) s0_q <= rx_s_q;
      if (edge_q == half)        s1_q <= rx_s_q;
    end
  end

  // third vote is the live sample at the decision edge
  assign bit_val = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
`else
  logic s1_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                  s1_q <= 1'b1;
    else if (edge_q == half)   s1_q <= rx_s_q;
  end

  assign bit_val = s1_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      p_q       <= 6'd8;
      edge_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      pen_q     <= 1'b0;
      ptyp_q    <= 1'b0;
      par_bad_q <= 1'b0;
      stop_ok_q <= 1'b0;
      pdata_q   <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      pen_q     <= pen_d;
      ptyp_q    <= ptyp_d;
      par_bad_q <= par_bad_d;
      stop_ok_q <= stop_ok_d;
      pdata_q   <= pdata_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    edge_d    = edge_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    pen_d     = pen_q;
    ptyp_d    = ptyp_q;
    par_bad_d = par_bad_q;
    stop_ok_d = stop_ok_q;
    pdata_d   = pdata_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;

    if (state_q != IDLE) edge_d = bit_last ? 6'd0 : edge_q + 6'd1;

    case (state_q)
      IDLE: begin
        // detection cycle is edge 0 of the start bit
        if (!rx_s_q) begin
          state_d   = START;
          edge_d    = 6'd1;
          p_d       = p_sel;
          pen_d     = PAR_EN;
          ptyp_d    = PAR_TYP;
          par_bad_d = 1'b0;
          bit_d     = '0;
        end
      end
      START: begin
        if (at_dec && bit_val) begin
          state_d = IDLE;
          edge_d  = 6'd0;
        end else if (bit_last) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_dec) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
        if (bit_last) begin
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            state_d = pen_q ? PARITY : STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (at_dec && (bit_val != ((^shift_q) ^ ptyp_q))) par_bad_d = 1'b1;
        if (bit_last) state_d = STOP;
      end
      STOP: begin
        if (at_dec) stop_ok_d = bit_val;
        if (bit_last) begin
          state_d = IDLE;
          if (par_bad_q)       pe_d = 1'b1;
          else if (!stop_ok_q) se_d = 1'b1;
          else begin
            dv_d    = 1'b1;
            pdata_d = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign P_DATA     = pdata_q;
  assign Data_Valid = dv_q;
  assign Par_Err    = pe_q;
  assign Stp_Err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;
  logic       CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0, PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_Valid, Par_Err, Stp_Err;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Par_Err(Par_Err),
    .Stp_Err(Stp_Err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // fl = {Data_Valid, Par_Err, Stp_Err}
  typedef struct { logic [2:0] fl; logic [7:0] d; int c; } evt_t;
  evt_t obs_q[$];
  evt_t exp_q[$];

  always @(negedge CLK) begin
    evt_t ev;
    if (RST && (Data_Valid || Par_Err || Stp_Err)) begin
      ev.fl = {Data_Valid, Par_Err, Stp_Err};
      ev.d  = P_DATA;
      ev.c  = cyc;
      obs_q.push_back(ev);
    end
  end

  int checks = 0, failures = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1 RX_IN = 1'b1;
    end
  endtask

  // gl: frame bit index (0=start) whose P/2 sample gets a 1-cycle inversion, -1 = none
  task automatic send_frame(input logic [7:0] d, input logic [5:0] pre, input bit pen,
                            input bit ptyp, input bit par_ok, input bit stop_v,
                            input int gl, input int nmax, input bit expect_it);
    int   p, n, start_c;
    logic b[0:10];
    logic rb[0:10];
    logic [7:0] rd;
    evt_t ev;
    p = (pre == 6'd16 || pre == 6'd32) ? int'(pre) : 8;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    n = 9;
    if (pen) begin b[n] = (^d) ^ ptyp ^ !par_ok; n++; end
    b[n] = stop_v; n++;
    for (int i = 0; i < n; i++) rb[i] = b[i];
`ifndef UART_RX_MAJORITY_EN
    if (gl >= 0) rb[gl] = !rb[gl];
`endif
    start_c = 0;
    for (int k = 0; k < n && k < nmax; k++) begin
      for (int e = 0; e < p; e++) begin
        @(posedge CLK); #1;
        if (k == 0 && e == 0) begin
          Prescale = pre; PAR_EN = pen; PAR_TYP = ptyp; start_c = cyc;
        end
        if (k == 2 && e == 0) begin
          Prescale = 6'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        end
        RX_IN = b[k] ^ ((k == gl) && (e == p / 2));
      end
    end
    if (expect_it) begin
      for (int i = 0; i < 8; i++) rd[i] = rb[i+1];
      if (pen && (rb[9] != ((^rd) ^ ptyp))) ev.fl = 3'b010;
      else if (!rb[n-1])                     ev.fl = 3'b001;
      else begin ev.fl = 3'b100; last_good = rd; end
      ev.d = last_good;
      // result pulse lands N*P after start detect, which trails the line by the 2-flop synchroniser
      ev.c = start_c + n * p + 2;
      exp_q.push_back(ev);
    end
  endtask

  task automatic drain();
    evt_t e, o;
    int   w;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      w = 0;
      while (obs_q.size() == 0 && w < 4000) begin @(posedge CLK); w++; end
      if (obs_q.size() == 0) begin
        chk("evt_timeout", obs_q.size(), 1);
        continue;
      end
      o = obs_q.pop_front();
      chk("flags", {29'd0, o.fl}, {29'd0, e.fl});
      chk("pdata_at_pulse", {24'd0, o.d}, {24'd0, e.d});
      chk("latency_cyc", o.c, e.c);
    end
    chk("extra_evts", obs_q.size(), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pre;
    int         gl;
    repeat (3) @(posedge CLK); #1;
    chk("rst_pdata", {24'd0, P_DATA}, 0);
    chk("rst_flags", {29'd0, Data_Valid, Par_Err, Stp_Err}, 0);
    RST = 1'b1;
    idle(4);

    send_frame(8'hA5, 6'd8, 1, 0, 1, 1, -1, 99, 1); idle(6); drain();
    chk("good_even_pdata", {24'd0, P_DATA}, 32'hA5);

    send_frame(8'h3C, 6'd16, 1, 1, 0, 1, -1, 99, 1); idle(6); drain();
    chk("par_err_keeps_pdata", {24'd0, P_DATA}, 32'hA5);

    send_frame(8'h81, 6'd8, 0, 0, 1, 0, -1, 99, 1); idle(4);
    send_frame(8'h7E, 6'd8, 0, 0, 1, 1, -1, 99, 1); idle(6); drain();
    chk("after_stop_err_pdata", {24'd0, P_DATA}, 32'h7E);

    @(posedge CLK); #1 Prescale = 6'd16; RX_IN = 1'b0;
    repeat (2) begin @(posedge CLK); #1 RX_IN = 1'b0; end
    idle(60); drain();
    send_frame(8'h55, 6'd16, 0, 0, 1, 1, -1, 99, 1); idle(6); drain();
    chk("after_glitch_pdata", {24'd0, P_DATA}, 32'h55);

    send_frame(8'h00, 6'd32, 0, 0, 1, 1, -1, 99, 1);
    send_frame(8'hFF, 6'd32, 0, 0, 1, 1, -1, 99, 1);
    send_frame(8'h99, 6'd32, 0, 0, 1, 1, -1, 5, 0);
    #2 RST = 1'b0;
    #1;
    chk("midrst_pdata", {24'd0, P_DATA}, 0);
    chk("midrst_flags", {29'd0, Data_Valid, Par_Err, Stp_Err}, 0);
    repeat (2) @(posedge CLK);
    #1 RX_IN = 1'b1; RST = 1'b1;
    last_good = 8'h00;
    idle(4); drain();
    send_frame(8'h12, 6'd32, 0, 0, 1, 1, -1, 99, 1); idle(6); drain();
    chk("after_rst_pdata", {24'd0, P_DATA}, 32'h12);

    send_frame(8'hF0, 6'd16, 0, 0, 1, 1, 4, 99, 1); idle(6); drain();
`ifdef UART_RX_MAJORITY_EN
    chk("glitch_bit3_pdata", {24'd0, P_DATA}, 32'hF0);
`else
    chk("glitch_bit3_pdata", {24'd0, P_DATA}, 32'hF8);
`endif

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(4))
        0: pre = 6'd8;
        1: pre = 6'd16;
        2: pre = 6'd32;
        default: pre = 6'($urandom);
      endcase
      gl = ($urandom_range(3) == 0) ? 1 + $urandom_range(7) : -1;
      send_frame(8'($urandom), pre, 1'($urandom), 1'($urandom), $urandom_range(3) != 0,
                 $urandom_range(3) != 0, gl, 99, 1);
      idle(3 + $urandom_range(20));
      drain();
      chk("rand_pdata", {24'd0, P_DATA}, {24'd0, last_good});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
